// File: rtl/morse_pkg.sv
// Shared types, constants and width helpers for the morse_tx serialiser.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned TICK_DIV_50MHZ_HALF_S = 25000000;
    localparam int unsigned TICK_DIV_SIM          = 4;

    // Width of the length field able to hold 0..pat_w.
    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // clog2 clamped to 1 so degenerate counters still get a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Loadable unit-period down-counter; o_tick_c marks the last clock of each unit.
module morse_tick_gen
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_clear,
    output logic o_tick_c
);

    localparam int unsigned DIV_W = clog2_min1(TICK_DIV);
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - DIV_W'(1);
        end
    end

    assign o_tick_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/morse_tx.sv
// Morse/pattern serialiser: plays a left-aligned unit pattern MSB-first on led,
// then a fixed off gap. Optional repeat mode under `define MORSE_TX_LOOP_EN.
module morse_tx
    import morse_pkg::*;
#(
    parameter  int unsigned PAT_W     = 14,
    parameter  int unsigned TICK_DIV  = TICK_DIV_50MHZ_HALF_S,
    parameter  int unsigned GAP_UNITS = 3,
    localparam int unsigned LEN_W     = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
`ifdef MORSE_TX_LOOP_EN
    input  logic             loop_en,
`endif
    input  logic             abort,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = clog2_min1(GAP_UNITS + 1);

    state_t           r_state, w_state_nxt;
    logic [PAT_W-1:0] r_shreg, w_shreg_nxt, w_shifted;
    logic [LEN_W-1:0] r_rem, w_rem_nxt, w_len_clamp;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic             r_led, w_led_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_accept, w_tick, w_div_load, w_finish;

`ifdef MORSE_TX_LOOP_EN
    logic [PAT_W-1:0] r_saved_pat;
    logic [LEN_W-1:0] r_saved_len;
`endif

    assign pat_ready   = (r_state == IDLE) && !abort;
    assign w_accept    = pat_valid && pat_ready;
    assign w_len_clamp = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign w_shifted   = r_shreg << 1;

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (r_state != IDLE),
        .i_load   (w_div_load),
        .i_clear  (abort),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_rem   <= '0;
            r_gap   <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_rem   <= w_rem_nxt;
            r_gap   <= w_gap_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef MORSE_TX_LOOP_EN
    // Copy of the accepted offer, replayed at the end of each repetition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_saved_pat <= '0;
            r_saved_len <= '0;
        end else if (w_accept && (w_len_clamp != '0)) begin
            r_saved_pat <= pat_data;
            r_saved_len <= w_len_clamp;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_rem_nxt   = r_rem;
        w_gap_nxt   = r_gap;
        w_led_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_div_load  = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_len_clamp != '0) begin
                        w_state_nxt = SEND;
                        w_shreg_nxt = pat_data;
                        w_rem_nxt   = w_len_clamp;
                        w_div_load  = 1'b1;
                        w_led_nxt   = pat_data[PAT_W-1];
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            SEND: begin
                w_led_nxt  = r_shreg[PAT_W-1];
                w_busy_nxt = 1'b1;
                if (w_tick) begin
                    if (r_rem > LEN_W'(1)) begin
                        w_shreg_nxt = w_shifted;
                        w_rem_nxt   = r_rem - LEN_W'(1);
                        w_led_nxt   = w_shifted[PAT_W-1];
                    end else if (GAP_UNITS > 0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_W'(GAP_UNITS);
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_finish    = 1'b1;
                    end
                end
            end
            GAP: begin
                w_busy_nxt = 1'b1;
                if (w_tick) begin
                    if (r_gap == GAP_W'(1)) begin
                        w_finish  = 1'b1;
                    end else begin
                        w_gap_nxt = r_gap - GAP_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Normal completion: done coincides with the first IDLE cycle (or a replay start).
        if (w_finish) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
            w_led_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
`ifdef MORSE_TX_LOOP_EN
            if (loop_en) begin
                w_state_nxt = SEND;
                w_shreg_nxt = r_saved_pat;
                w_rem_nxt   = r_saved_len;
                w_led_nxt   = r_saved_pat[PAT_W-1];
                w_busy_nxt  = 1'b1;
            end
`endif
        end

        if (abort) begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_rem_nxt   = '0;
            w_gap_nxt   = '0;
            w_led_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_div_load  = 1'b0;
        end
    end

    assign led  = r_led;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with PAT_W=14, TICK_DIV=4, GAP_UNITS=3.
module tb_morse_tx;

    localparam int unsigned PAT_W = 14;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pat_valid = 1'b0;
    logic             pat_ready;
    logic [PAT_W-1:0] pat_data = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             loop_en = 1'b0;
    logic             abort = 1'b0;
    logic             led, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    morse_tx #(
        .PAT_W     (PAT_W),
        .TICK_DIV  (4),
        .GAP_UNITS (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
`ifdef MORSE_TX_LOOP_EN
        .loop_en   (loop_en),
`endif
        .abort     (abort),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0]       exp6;
        logic [PAT_W-1:0] full;
        logic             seen_done;

        // Reset state
        #3;
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        #4 reset_n = 1'b1;
        step();
        chk("rst_ready", 32'(pat_ready), 1);

        // Basic send, with an ignored offer at cycle 10
        exp6      = 6'b101010;
        pat_data  = 14'b10101000000000;
        pat_len   = 4'd6;
        pat_valid = 1'b1;
        step();
        for (int c = 1; c <= 36; c++) begin
            pat_valid = (c == 10);
            pat_data  = (c == 10) ? 14'h3fff : 14'b10101000000000;
            pat_len   = (c == 10) ? 4'd14 : 4'd6;
            chk($sformatf("b_led_c%0d", c), 32'(led), (c <= 24) ? 32'(exp6[5 - (c - 1) / 4]) : 0);
            chk($sformatf("b_busy_c%0d", c), 32'(busy), 1);
            chk($sformatf("b_done_c%0d", c), 32'(done), 0);
            chk($sformatf("b_ready_c%0d", c), 32'(pat_ready), 0);
            step();
        end
        pat_valid = 1'b0;
        chk("b_done37", 32'(done), 1);
        chk("b_busy37", 32'(busy), 0);
        chk("b_led37", 32'(led), 0);
        chk("b_ready37", 32'(pat_ready), 1);
        step();
        chk("b_done38", 32'(done), 0);

        // Full width, clamped length
        full      = 14'b11101011101110;
        pat_data  = full;
        pat_len   = 4'd15;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            chk($sformatf("f_led_c%0d", c), 32'(led), (c <= 56) ? 32'(full[13 - (c - 1) / 4]) : 0);
            chk($sformatf("f_done_c%0d", c), 32'(done), 0);
            step();
        end
        chk("f_done69", 32'(done), 1);
        step();

        // Zero length
        pat_data  = 14'h3fff;
        pat_len   = 4'd0;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        chk("z_done", 32'(done), 1);
        chk("z_led", 32'(led), 0);
        chk("z_busy", 32'(busy), 0);
        step();
        chk("z_done_off", 32'(done), 0);
        chk("z_led2", 32'(led), 0);

        // Back-to-back with pat_valid held
        pat_data  = 14'b10000000000000;
        pat_len   = 4'd1;
        pat_valid = 1'b1;
        step();
        pat_data  = 14'b11000000000000;
        pat_len   = 4'd2;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("bb_led_c%0d", c), 32'(led), (c <= 4) ? 1 : 0);
            step();
        end
        chk("bb_done17", 32'(done), 1);
        chk("bb_ready17", 32'(pat_ready), 1);
        step();
        pat_valid = 1'b0;
        chk("bb_led18", 32'(led), 1);
        chk("bb_busy18", 32'(busy), 1);
        chk("bb_done18", 32'(done), 0);
        for (int c = 18; c < 38; c++) step();
        chk("bb_done38", 32'(done), 1);
        step();

        // Abort mid-SEND
        pat_data  = 14'h3fff;
        pat_len   = 4'd14;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("a_led_c%0d", c), 32'(led), 1);
            if (c == 10) abort = 1'b1;
            if (c < 10) step();
        end
        step();
        chk("a_led11", 32'(led), 0);
        chk("a_busy11", 32'(busy), 0);
        chk("a_done11", 32'(done), 0);
        chk("a_ready_blk", 32'(pat_ready), 0);
        abort = 1'b0;
        #1;
        chk("a_ready_rel", 32'(pat_ready), 1);
        seen_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step();
            seen_done = seen_done | done | busy;
        end
        chk("a_no_done", 32'(seen_done), 0);

        // Abort in IDLE blocks acceptance
        abort     = 1'b1;
        pat_len   = 4'd3;
        pat_valid = 1'b1;
        #1;
        chk("ai_ready", 32'(pat_ready), 0);
        step();
        chk("ai_busy", 32'(busy), 0);
        chk("ai_done", 32'(done), 0);
        abort     = 1'b0;
        pat_valid = 1'b0;
        step();

        // Async reset mid-SEND
        pat_data  = 14'h3fff;
        pat_len   = 4'd14;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        for (int c = 1; c < 5; c++) step();
        chk("r_led_pre", 32'(led), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_led", 32'(led), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_done", 32'(done), 0);
        #2 reset_n = 1'b1;
        step();
        chk("r_ready", 32'(pat_ready), 1);
        chk("r_busy_post", 32'(busy), 0);
        pat_data  = 14'b10000000000000;
        pat_len   = 4'd1;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        chk("r_led_new", 32'(led), 1);
        for (int c = 1; c < 17; c++) step();
        chk("r_done_new", 32'(done), 1);
        step();

`ifdef MORSE_TX_LOOP_EN
        // Looping: 3 units + 3 gap units => done every 24 cycles
        loop_en   = 1'b1;
        pat_data  = 14'b11100000000000;
        pat_len   = 4'd3;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 30) loop_en = 1'b0;
            chk($sformatf("l_done_c%0d", c), 32'(done), (c == 25 || c == 49) ? 1 : 0);
            chk($sformatf("l_ready_c%0d", c), 32'(pat_ready), (c >= 49) ? 1 : 0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
Parametrised Morse/pattern serialiser: accepts a left-aligned on/off unit pattern and a length through a valid/ready handshake. Plays the pattern MSB-first on a single LED output, one unit per TICK_DIV clocks, then holds a fixed inter-symbol gap. Generalises the fixed 14-bit, SW-selected letter shifter with variable width and length, busy/done status, abort, and optional looping. Sits between a letter-encoding table (or a future text buffer) and the board LED.

Parameters:
PAT_W, 14, pattern register width in units; pattern is MSB-first.
TICK_DIV, 25000000, clocks per Morse unit (0.5 s at 50 MHz); must be >= 1.
GAP_UNITS, 3, units of forced LED-off after the last pattern unit; 0 allowed.

Ports:
clk  input  1  system clock, 50 MHz on board.
reset_n  input  1  asynchronous active-low reset.
pat_valid  input  1  pattern offer.
pat_ready  output  1  block can accept; equals (state==IDLE) && !abort.
pat_data  input  PAT_W  unit pattern, bit PAT_W-1 is sent first; 1=LED on.
pat_len  input  LEN_W  number of units to send; LEN_W = clog2(PAT_W+1).
abort  input  1  synchronous cancel.
led  output  1  serial LED drive, registered.
busy  output  1  high in SEND or GAP.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, reset_n=0): state IDLE, led=0, busy=0, done=0, shift reg=0, counters=0. pat_ready=1 once reset_n=1.
- States: IDLE, SEND, GAP.
- IDLE -> SEND: on pat_valid && pat_ready at edge N, if pat_len != 0.
  - Capture pat_data into shift reg.
  - Set remaining=min(pat_len, PAT_W); pat_len > PAT_W is clamped.
  - Load divider with TICK_DIV-1.
  - led = pat_data[PAT_W-1] from cycle N+1.
- pat_len == 0 accepted: no SEND/GAP, led stays 0, done pulses at N+1, state stays IDLE.
- SEND: led = shreg[PAT_W-1]. Divider counts down; tick when divider == 0, then divider reloads TICK_DIV-1. Each unit lasts exactly TICK_DIV cycles. On tick:
  - if remaining > 1: shift left with 0 fill, remaining -= 1.
  - if remaining == 1: if GAP_UNITS > 0, go to GAP with gap counter=GAP_UNITS and led=0; otherwise go to IDLE with done=1.
- GAP: led=0. Gap counter decrements on each tick; when a tick occurs with gap counter == 1, go to IDLE and done=1 in that same cycle.
- done is high for exactly one cycle, coincident with first IDLE cycle; pat_ready is also high that cycle. A new pattern accepted then starts SEND next cycle, with no extra idle unit.
- abort (highest priority after reset): next state IDLE, led=0, divider/counters cleared, no done pulse. abort in IDLE blocks acceptance (pat_ready=0).
- pat_valid while busy is ignored; no queueing.
- Total latency, handshake to done: (len + GAP_UNITS) * TICK_DIV cycles.
- All arithmetic is unsigned. Divider width is clog2(TICK_DIV); gap counter width is clog2(GAP_UNITS+1).

Optional Feature:
Macro MORSE_TX_LOOP_EN.
- Defined: adds input port loop_en (1 bit) and a PAT_W-bit saved copy of the accepted pattern plus its length.
  - At GAP completion (or SEND completion when GAP_UNITS=0) with loop_en=1: reload the saved pattern and length, go to SEND, pulse done, keep pat_ready=0.
  - If loop_en is deasserted, the current repetition finishes and the block returns to IDLE normally.
  - abort stops immediately.
- Undefined: no loop_en port, no saved copy; the block always returns to IDLE.

Decomposition:
- Package morse_pkg: state typedef (IDLE/SEND/GAP); localparams TICK_DIV_50MHZ_HALF_S=25000000 and TICK_DIV_SIM=4; helper function for LEN_W.
- One sub-module, morse_tick_gen: loadable down-counter with clear input, TICK_DIV parameter, one-cycle tick output.

Test Plan:
- Basic send: PAT_W=14, TICK_DIV=4, GAP_UNITS=3; send 14'b10101000000000, len=6 at edge 0 -> led 1,0,1,0,1,0 for 4 cycles each over cycles 1-24, led=0 cycles 25-36, done=1 only at cycle 37, busy=1 cycles 1-36.
- Full width, clamped length: 14'b11101011101110 with pat_len=15 -> 14 units played MSB-first; done at (14+3)*4+1 = cycle 69.
- Zero length and back-to-back:
  - pat_len=0 -> done at cycle 1, led never 1.
  - pat_valid held high with a second pattern -> second accepted on the done cycle; its first unit appears on the next cycle.
- Abort and ignored offers:
  - abort at cycle 10 of SEND -> led=0 and busy=0 from cycle 11; no done; pat_ready=1 once abort drops.
  - pat_valid during busy -> ignored.
- Async reset: reset_n=0 mid-SEND, asserted between clock edges -> led, busy, done go 0 immediately; after release, state IDLE and pat_ready=1.
- MORSE_TX_LOOP_EN defined, loop_en=1, len=3 pattern 3'b111, GAP_UNITS=1 -> done every 16 cycles, pat_ready stays 0. Dropping loop_en mid-pattern -> exactly one further done, then IDLE.
